// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and read-master state
// encoding for the edge-detection read path.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    DONE,
    ERROR
  } rd_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small registered pixel FIFO; head byte is always
// presented on rdata, pointers wrap modulo DEPTH.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ahb_read_master.sv
// Non-pipelined AHB-Lite single-byte read master that
// feeds returned pixels into a small backpressured FIFO.
module ahb_read_master
  import ahb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          start,
  input  logic [AW-1:0] curr_addr,
  input  logic          end_of_image,
  output logic          addr_update_enable_r,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [2:0]    HBURST,
  input  logic          HREADY,
  input  logic          HRESP,
  input  logic [31:0]   HRDATA,
  output logic [7:0]    pixel_data,
  output logic          pixel_valid,
  input  logic          pixel_ready,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int CW = $clog2(DEPTH) + 1;

  rd_state_t     state_q;
  rd_state_t     state_d;
  logic [1:0]    lane_q;
  logic          last_q;
  logic          latch;
  logic          push;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic [7:0]    wdata;

  assign HWRITE = 1'b0;
  assign HSIZE  = HSIZE_BYTE;
  assign HBURST = HBURST_SINGLE;

  // Little-endian lane select of the latched byte offset
  assign wdata = HRDATA[{lane_q, 3'b000} +: 8];

  assign pixel_valid = !empty;
  assign busy  = (state_q == ADDR) || (state_q == DATA);
  assign done  = (state_q == DONE) && (count == '0);
  assign error = (state_q == ERROR);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      lane_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        lane_q <= curr_addr[1:0];
        last_q <= end_of_image;
      end
    end
  end

  always_comb begin
    state_d              = state_q;
    HTRANS               = HTRANS_IDLE;
    HADDR                = '0;
    latch                = 1'b0;
    push                 = 1'b0;
    addr_update_enable_r = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = ADDR;
      end
      ADDR: begin
        // Only issue when the pixel is guaranteed a slot
        if (!full) begin
          HTRANS = HTRANS_NONSEQ;
          HADDR  = curr_addr;
          if (HREADY) begin
            latch   = 1'b1;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (HRESP) begin
          state_d = ERROR;
        end else if (HREADY) begin
          push                 = 1'b1;
          addr_update_enable_r = 1'b1;
          state_d              = last_q ? DONE : ADDR;
        end
      end
      DONE, ERROR: begin
        state_d = state_q;
      end
      default: state_d = IDLE;
    endcase
  end

  pixel_fifo #(
    .DEPTH(DEPTH),
    .W    (8)
  ) u_fifo (
    .clk  (HCLK),
    .n_rst(HRESETn),
    .push (push),
    .wdata(wdata),
    .pop  (pixel_ready),
    .rdata(pixel_data),
    .empty(empty),
    .full (full),
    .count(count)
  );

endmodule

// File: tb/tb_ahb_read_master.sv
// Directed bench: AHB slave model, address-update model
// and a pixel scoreboard checked with immediate asserts.
module tb_ahb_read_master;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        start;
  logic [31:0] curr_addr;
  logic        end_of_image;
  logic        addr_update_enable_r;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [7:0]  pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        busy;
  logic        done;
  logic        error;

  int errs   = 0;
  int checks = 0;

  logic [31:0] m_base   = 32'h0;
  logic [31:0] m_stride = 32'h1;
  int m_idx  = 0;
  int m_idx0 = 0;
  int m_last = 0;

  int wait_cycles = 0;
  int err_at      = -1;
  int nonseq_cnt  = 0;
  int upd_cnt     = 0;
  int pop_cnt     = 0;

  bit          dphase  = 1'b0;
  int          e_stage = 0;
  int          dwait   = 0;
  logic [31:0] d_addr  = '0;
  logic [7:0]  d_exp   = '0;
  logic [7:0]  q[$];

  int n0, u0, p0;

  assign curr_addr =
    m_base + m_stride * 32'(m_idx - m_idx0);
  assign end_of_image = ((m_idx - m_idx0) == m_last);

  always #5 HCLK = ~HCLK;

  ahb_read_master #(
    .DEPTH(4),
    .AW   (32)
  ) dut (
    .HCLK                (HCLK),
    .HRESETn             (HRESETn),
    .start               (start),
    .curr_addr           (curr_addr),
    .end_of_image        (end_of_image),
    .addr_update_enable_r(addr_update_enable_r),
    .HADDR               (HADDR),
    .HTRANS              (HTRANS),
    .HWRITE              (HWRITE),
    .HSIZE               (HSIZE),
    .HBURST              (HBURST),
    .HREADY              (HREADY),
    .HRESP               (HRESP),
    .HRDATA              (HRDATA),
    .pixel_data          (pixel_data),
    .pixel_valid         (pixel_valid),
    .pixel_ready         (pixel_ready),
    .busy                (busy),
    .done                (done),
    .error               (error)
  );

  // Memory image: every byte differs by lane and word
  function automatic logic [7:0] f(
    input logic [31:0] a
  );
    return (8'hDD - 8'h11 * {6'd0, a[1:0]}) ^ a[9:2];
  endfunction

  function automatic logic [31:0] word(
    input logic [31:0] a
  );
    return {f({a[31:2], 2'd3}), f({a[31:2], 2'd2}),
            f({a[31:2], 2'd1}), f({a[31:2], 2'd0})};
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sample pre-edge, advance one clock, drive slave
  task automatic tick();
    if (!HRESETn) begin
      dphase  = 1'b0;
      e_stage = 0;
    end else begin
      if (addr_update_enable_r) begin
        upd_cnt++;
        m_idx++;
      end
      if (dphase) begin
        if (e_stage == 1) begin
          e_stage = 2;
        end else if (e_stage == 2) begin
          dphase  = 1'b0;
          e_stage = 0;
        end else if (HREADY) begin
          dphase = 1'b0;
          q.push_back(d_exp);
        end else begin
          dwait--;
        end
      end else if (HTRANS == HTRANS_NONSEQ && HREADY) begin
        check("haddr", HADDR, curr_addr);
        check("hctl", {25'd0, HWRITE, HSIZE, HBURST}, 0);
        e_stage = (nonseq_cnt == err_at) ? 1 : 0;
        nonseq_cnt++;
        dphase = 1'b1;
        d_addr = HADDR;
        d_exp  = f(curr_addr);
        dwait  = wait_cycles;
      end
      if (pixel_valid && pixel_ready) begin
        pop_cnt++;
        check("sb_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0)
          check("pixel", 32'(pixel_data),
                32'(q.pop_front()));
      end
    end
    @(posedge HCLK);
    #1;
    if (!HRESETn || !dphase) begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = '0;
    end else begin
      HRDATA = word(d_addr);
      HRESP  = (e_stage != 0);
      HREADY = (e_stage == 2) ||
               (e_stage == 0 && dwait == 0);
    end
    @(negedge HCLK);
  endtask

  task automatic do_reset();
    check("q_empty_at_reset", 32'(q.size()), 0);
    q.delete();
    HRESETn = 1'b0;
    tick();
    tick();
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic cfg(
    input logic [31:0] base,
    input logic [31:0] stride,
    input int          last,
    input int          waits
  );
    m_base      = base;
    m_stride    = stride;
    m_last      = last;
    m_idx0      = m_idx;
    wait_cycles = waits;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic snap();
    n0 = nonseq_cnt;
    u0 = upd_cnt;
    p0 = pop_cnt;
  endtask

  task automatic chk_reset_outs(input string t);
    check({t, "_htrans"}, 32'(HTRANS), 0);
    check({t, "_haddr"}, HADDR, 0);
    check({t, "_upd"}, 32'(addr_update_enable_r), 0);
    check({t, "_valid"}, 32'(pixel_valid), 0);
    check({t, "_busy"}, 32'(busy), 0);
    check({t, "_done"}, 32'(done), 0);
    check({t, "_error"}, 32'(error), 0);
  endtask

  initial begin
    HRESETn     = 1'b0;
    start       = 1'b0;
    pixel_ready = 1'b0;
    HREADY      = 1'b1;
    HRESP       = 1'b0;
    HRDATA      = '0;
    tick();
    tick();
    chk_reset_outs("rst");
    HRESETn = 1'b1;
    tick();

    // 1: zero-wait single read, lane 2 of 0xAABBCCDD
    cfg(32'h0000_1002, 32'h1, 0, 0);
    snap();
    pulse_start();
    check("t1_nonseq", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    check("t1_haddr", HADDR, 32'h0000_1002);
    check("t1_busy", 32'(busy), 1);
    tick();
    check("t1_upd", 32'(addr_update_enable_r), 1);
    check("t1_idle", 32'(HTRANS), 0);
    check("t1_word", HRDATA, 32'hAABB_CCDD);
    check("t1_novalid", 32'(pixel_valid), 0);
    tick();
    check("t1_valid", 32'(pixel_valid), 1);
    check("t1_data", 32'(pixel_data), 32'hBB);
    check("t1_upd_once", 32'(addr_update_enable_r), 0);
    check("t1_notdone", 32'(done), 0);
    pixel_ready = 1'b1;
    tick();
    tick();
    check("t1_empty", 32'(pixel_valid), 0);
    check("t1_done", 32'(done), 1);
    check("t1_reads", nonseq_cnt - n0, 1);
    check("t1_upds", upd_cnt - u0, 1);
    check("t1_pops", pop_cnt - p0, 1);

    // 2: three data-phase wait states
    do_reset();
    cfg(32'h0000_2000, 32'h1, 0, 3);
    snap();
    pulse_start();
    check("t2_nonseq", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_w_htrans", 32'(HTRANS), 0);
      check("t2_w_upd", 32'(addr_update_enable_r), 0);
      check("t2_w_valid", 32'(pixel_valid), 0);
    end
    tick();
    check("t2_upd", 32'(addr_update_enable_r), 1);
    tick();
    check("t2_valid", 32'(pixel_valid), 1);
    tick();
    tick();
    check("t2_done", 32'(done), 1);
    check("t2_upds", upd_cnt - u0, 1);
    check("t2_pops", pop_cnt - p0, 1);

    // 3: backpressure fills FIFO, then drains in order
    do_reset();
    cfg(32'h0000_3010, 32'h1, 7, 0);
    pixel_ready = 1'b0;
    snap();
    pulse_start();
    for (int i = 0; i < 20; i++) tick();
    check("t3_reads_full", nonseq_cnt - n0, 4);
    check("t3_htrans_full", 32'(HTRANS), 0);
    check("t3_haddr_full", HADDR, 0);
    check("t3_busy_full", 32'(busy), 1);
    check("t3_sb_full", 32'(q.size()), 4);
    pixel_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      tick();
    end
    check("t3_done", 32'(done), 1);
    check("t3_reads", nonseq_cnt - n0, 8);
    check("t3_upds", upd_cnt - u0, 8);
    check("t3_pops", pop_cnt - p0, 8);

    // 4: end_of_image on 3rd address, later start ignored
    do_reset();
    cfg(32'h0000_4003, 32'h5, 2, 0);
    snap();
    pulse_start();
    for (int i = 0; i < 60; i++) begin
      if (done) break;
      tick();
    end
    check("t4_done", 32'(done), 1);
    check("t4_reads", nonseq_cnt - n0, 3);
    check("t4_upds", upd_cnt - u0, 3);
    check("t4_pops", pop_cnt - p0, 3);
    pulse_start();
    for (int i = 0; i < 10; i++) tick();
    check("t4_no_reissue", nonseq_cnt - n0, 3);
    check("t4_still_done", 32'(done), 1);
    check("t4_idle", 32'(busy), 0);

    // 5: two-cycle error response on 2nd read
    do_reset();
    cfg(32'h0000_5000, 32'h1, 7, 0);
    pixel_ready = 1'b0;
    err_at = nonseq_cnt + 1;
    snap();
    pulse_start();
    for (int i = 0; i < 30; i++) begin
      if (error) break;
      tick();
    end
    for (int i = 0; i < 5; i++) tick();
    check("t5_error", 32'(error), 1);
    check("t5_reads", nonseq_cnt - n0, 2);
    check("t5_upds", upd_cnt - u0, 1);
    check("t5_htrans", 32'(HTRANS), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_valid", 32'(pixel_valid), 1);
    pixel_ready = 1'b1;
    tick();
    tick();
    check("t5_pops", pop_cnt - p0, 1);
    check("t5_drained", 32'(pixel_valid), 0);
    check("t5_notdone", 32'(done), 0);
    err_at = -1;

    // 6: reset during data phase, then restart
    do_reset();
    cfg(32'h0000_6004, 32'h1, 3, 2);
    snap();
    pulse_start();
    tick();
    check("t6_in_data", 32'(busy), 1);
    check("t6_data_idle", 32'(HTRANS), 0);
    HRESETn = 1'b0;
    #1;
    chk_reset_outs("t6_rst");
    tick();
    tick();
    HRESETn = 1'b1;
    tick();
    check("t6_post_idle", 32'(HTRANS), 0);
    check("t6_no_upd", upd_cnt - u0, 0);
    pulse_start();
    check("t6_nonseq", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    check("t6_haddr", HADDR, 32'h0000_6004);
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      tick();
    end
    check("t6_done", 32'(done), 1);
    check("t6_upds", upd_cnt - u0, 4);
    check("t6_pops", pop_cnt - p0, 4);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
